// File: rtl/sw_led_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sw_led_scheduler                                                |
// | Brief    : switch debounce and board-LED ownership (pattern / HPS / flash) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sw_led_scheduler #(
    parameter int TICK_DIV    = 50000,
    parameter int DB_SAMPLES  = 8,
    parameter int PAT_TICKS   = 100,
    parameter int FLASH_TICKS = 500
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [9:0] sw_raw,
    input  logic       hps_h2f_rst_n,
    input  logic [9:0] hps_leds,
    output logic [9:0] sw_db,
    output logic       sw_change,
    output logic [9:0] led_out,
    output logic [1:0] owner
);

    localparam int c_tick_w  = $clog2(TICK_DIV);
    localparam int c_db_w    = $clog2(DB_SAMPLES + 1);
    localparam int c_pat_w   = $clog2(PAT_TICKS + 1);
    localparam int c_flash_w = $clog2(FLASH_TICKS + 1);

    localparam logic [1:0] c_st_pattern = 2'd0;
    localparam logic [1:0] c_st_hps     = 2'd1;
    localparam logic [1:0] c_st_flash   = 2'd2;

    logic [9:0]           r_sw_meta;
    logic [9:0]           r_sw_sync;
    logic                 r_hps_meta;
    logic                 r_hps_sync;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic                 w_tick;
    logic [c_db_w-1:0]    r_db_cnt [10];
    logic [9:0]           w_db_flip;
    logic [9:0]           r_sw_db;
    logic                 r_sw_change;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_flash_w-1:0] r_flash_cnt;
    logic [c_pat_w-1:0]   r_pat_step;
    logic [3:0]           r_pat_pos;
    logic                 r_pat_up;
    logic [9:0]           r_hps_leds_q;
    logic [9:0]           r_led_out;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_hps_meta <= 1'b0;
            r_hps_sync <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_sw_meta  <= sw_raw;
            r_sw_sync  <= r_sw_meta;
            r_hps_meta <= hps_h2f_rst_n;
            r_hps_sync <= r_hps_meta;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == c_tick_w'(TICK_DIV - 1));

    // A bit flips on the tick whose sample would bring its count to DB_SAMPLES.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            w_db_flip[i] = w_tick && (r_sw_sync[i] != r_sw_db[i]) &&
                           (r_db_cnt[i] == c_db_w'(DB_SAMPLES - 1));
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 10; i++) begin
                r_db_cnt[i] <= '0;
            end
            r_sw_db     <= '0;
            r_sw_change <= 1'b0;
        end else begin
            if (w_tick) begin
                for (int i = 0; i < 10; i++) begin
                    if ((r_sw_sync[i] == r_sw_db[i]) || w_db_flip[i]) begin
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end
            end
            r_sw_db     <= r_sw_db ^ w_db_flip;
            r_sw_change <= |w_db_flip;
        end
    end

    // A switch change wins over every other transition, including retrigger in FLASH.
    always_comb begin
        w_state_nxt = r_state;
        if (r_sw_change) begin
            w_state_nxt = c_st_flash;
        end else begin
            case (r_state)
                c_st_pattern: if (r_hps_sync)  w_state_nxt = c_st_hps;
                c_st_hps:     if (!r_hps_sync) w_state_nxt = c_st_pattern;
                c_st_flash: begin
                    if (w_tick && (r_flash_cnt == c_flash_w'(1))) begin
                        w_state_nxt = r_hps_sync ? c_st_hps : c_st_pattern;
                    end
                end
                default: w_state_nxt = c_st_pattern;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= c_st_pattern;
            r_flash_cnt  <= '0;
            r_pat_step   <= '0;
            r_pat_pos    <= 4'd0;
            r_pat_up     <= 1'b1;
            r_hps_leds_q <= '0;
            r_led_out    <= 10'd1;
        end else begin
            r_state <= w_state_nxt;

            if (r_sw_change) begin
                r_flash_cnt <= c_flash_w'(FLASH_TICKS);
            end else if ((r_state == c_st_flash) && w_tick && (r_flash_cnt != '0)) begin
                r_flash_cnt <= r_flash_cnt - 1'b1;
            end

            if ((w_state_nxt == c_st_pattern) && (r_state != c_st_pattern)) begin
                r_pat_step <= '0;
                r_pat_pos  <= 4'd0;
                r_pat_up   <= 1'b1;
            end else if ((r_state == c_st_pattern) && (w_state_nxt == c_st_pattern) && w_tick) begin
                if (r_pat_step == c_pat_w'(PAT_TICKS - 1)) begin
                    r_pat_step <= '0;
                    if (r_pat_up) begin
                        if (r_pat_pos == 4'd9) begin
                            r_pat_pos <= 4'd8;
                            r_pat_up  <= 1'b0;
                        end else begin
                            r_pat_pos <= r_pat_pos + 4'd1;
                        end
                    end else begin
                        if (r_pat_pos == 4'd0) begin
                            r_pat_pos <= 4'd1;
                            r_pat_up  <= 1'b1;
                        end else begin
                            r_pat_pos <= r_pat_pos - 4'd1;
                        end
                    end
                end else begin
                    r_pat_step <= r_pat_step + 1'b1;
                end
            end

            r_hps_leds_q <= hps_leds;
            case (r_state)
                c_st_hps:   r_led_out <= r_hps_leds_q;
                c_st_flash: r_led_out <= r_sw_db;
                default:    r_led_out <= 10'd1 << r_pat_pos;
            endcase
        end
    end

    assign sw_db     = r_sw_db;
    assign sw_change = r_sw_change;
    assign led_out   = r_led_out;
    assign owner     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sw_led_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sw_led_scheduler                                             |
// | Brief    : bench for sw_led_scheduler against a behavioural model          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sw_led_scheduler;

    localparam int TICK_DIV    = 4;
    localparam int DB_SAMPLES  = 3;
    localparam int PAT_TICKS   = 2;
    localparam int FLASH_TICKS = 5;

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b1;
    logic [9:0] sw_raw        = '0;
    logic       hps_h2f_rst_n = 1'b0;
    logic [9:0] hps_leds      = '0;
    logic [9:0] sw_db;
    logic       sw_change;
    logic [9:0] led_out;
    logic [1:0] owner;

    sw_led_scheduler #(
        .TICK_DIV   (TICK_DIV),
        .DB_SAMPLES (DB_SAMPLES),
        .PAT_TICKS  (PAT_TICKS),
        .FLASH_TICKS(FLASH_TICKS)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .sw_raw       (sw_raw),
        .hps_h2f_rst_n(hps_h2f_rst_n),
        .hps_leds     (hps_leds),
        .sw_db        (sw_db),
        .sw_change    (sw_change),
        .led_out      (led_out),
        .owner        (owner)
    );

    always #5 clk_clk = ~clk_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Triangle walk: step count -> LED index 0..9..0..
    function automatic int tri_pos(input int p);
        int q;
        q = p % 18;
        return (q <= 9) ? q : 18 - q;
    endfunction

    // Behavioural model: time in edges since reset, pattern as a step count.
    int         m_edges;
    logic [9:0] m_sw1, m_sw2;
    logic       m_h1, m_h2;
    logic [9:0] m_db;
    int         m_dbc [10];
    logic       m_chg;
    int         m_owner;
    int         m_flash;
    int         m_steps;
    int         m_sub;
    logic [9:0] m_hq;
    logic [9:0] m_led;

    task automatic model_reset();
        m_edges = 0;
        m_sw1 = '0; m_sw2 = '0; m_h1 = 1'b0; m_h2 = 1'b0;
        m_db = '0; m_chg = 1'b0;
        for (int b = 0; b < 10; b++) m_dbc[b] = 0;
        m_owner = 0; m_flash = 0; m_steps = 0; m_sub = 0;
        m_hq = '0; m_led = 10'd1;
    endtask

    task automatic model_update();
        bit         tick;
        logic [9:0] n_db;
        int         n_own;
        m_edges++;
        tick = (m_edges % TICK_DIV) == 0;
        n_db = m_db;
        if (tick) begin
            for (int b = 0; b < 10; b++) begin
                if (m_sw2[b] != m_db[b]) begin
                    if (m_dbc[b] + 1 == DB_SAMPLES) begin
                        n_db[b]  = ~m_db[b];
                        m_dbc[b] = 0;
                    end else begin
                        m_dbc[b]++;
                    end
                end else begin
                    m_dbc[b] = 0;
                end
            end
        end
        case (m_owner)
            0: begin m_led = '0; m_led[tri_pos(m_steps)] = 1'b1; end
            1: m_led = m_hq;
            default: m_led = m_db;
        endcase
        n_own = m_owner;
        if (m_chg) begin
            n_own   = 2;
            m_flash = FLASH_TICKS;
        end else if (m_owner == 0) begin
            if (m_h2) n_own = 1;
        end else if (m_owner == 1) begin
            if (!m_h2) n_own = 0;
        end else if (tick) begin
            m_flash--;
            if (m_flash == 0) n_own = m_h2 ? 1 : 0;
        end
        if (n_own == 0 && m_owner != 0) begin
            m_steps = 0;
            m_sub   = 0;
        end else if (n_own == 0 && m_owner == 0 && tick) begin
            m_sub++;
            if (m_sub == PAT_TICKS) begin
                m_sub = 0;
                m_steps++;
            end
        end
        m_chg   = (n_db != m_db);
        m_db    = n_db;
        m_owner = n_own;
        m_hq    = hps_leds;
        m_sw2   = m_sw1;
        m_sw1   = sw_raw;
        m_h2    = m_h1;
        m_h1    = hps_h2f_rst_n;
    endtask

    task automatic step();
        @(posedge clk_clk);
        if (!reset_reset_n) model_reset();
        else model_update();
        #1;
        chk("sw_db", 32'(sw_db), 32'(m_db));
        chk("sw_change", 32'(sw_change), 32'(m_chg));
        chk("led_out", 32'(led_out), 32'(m_led));
        chk("owner", 32'(owner), 32'(m_owner));
    endtask

    task automatic wait_change(input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (sw_change) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Counts cycles spent in FLASH after a sw_change; checks the LED shows exp_led.
    task automatic flash_run(input logic [9:0] exp_led, output int n);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (k == 1) chk("flash_led", 32'(led_out), 32'(exp_led));
            if (owner == 2'd2) n++;
            else break;
        end
    endtask

    typedef struct {
        logic [9:0] sw;
        logic       hps;
        logic [9:0] leds;
        int         hold;
        int         exp_owner;
        logic [9:0] exp_db;
        logic [9:0] exp_led;
        bit         chk_led;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int pulses;
        int off_owner;
        int idx;

        vecs[0] = '{10'h000, 1'b1, 10'h3C3, 60, 1, 10'h000, 10'h3C3, 1'b1};
        vecs[1] = '{10'h2A5, 1'b1, 10'h011, 60, 1, 10'h2A5, 10'h011, 1'b1};
        vecs[2] = '{10'h2A5, 1'b0, 10'h011, 60, 0, 10'h2A5, 10'h000, 1'b0};
        vecs[3] = '{10'h3FF, 1'b0, 10'h000, 60, 0, 10'h3FF, 10'h000, 1'b0};
        vecs[4] = '{10'h3FF, 1'b1, 10'h155, 60, 1, 10'h3FF, 10'h155, 1'b1};
        vecs[5] = '{10'h001, 1'b1, 10'h200, 60, 1, 10'h001, 10'h200, 1'b1};

        model_reset();
        #2 reset_reset_n = 1'b0;
        #1;
        chk("rst_led", 32'(led_out), 32'h001);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_sw_db", 32'(sw_db), 32'd0);
        chk("rst_sw_change", 32'(sw_change), 32'd0);
        repeat (3) step();
        reset_reset_n = 1'b1;

        // Idle pattern walk: one step every PAT_TICKS*TICK_DIV cycles.
        repeat (4) step();
        for (int i = 0; i < 19; i++) begin
            chk("walk_led", 32'(led_out), 32'(10'd1 << tri_pos(i)));
            chk("walk_owner", 32'(owner), 32'd0);
            repeat (8) step();
        end

        // HPS takes over.
        hps_leds = 10'h2AA;
        hps_h2f_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (owner == 2'd1) break;
        end
        chk("hps_owner", 32'(owner), 32'd1);
        step();
        chk("hps_led", 32'(led_out), 32'h2AA);
        hps_leds = 10'h155;
        step();
        chk("hps_led_lag1", 32'(led_out), 32'h2AA);
        step();
        chk("hps_led_lag2", 32'(led_out), 32'h155);

        // Switch change and flash.
        sw_raw = 10'h00F;
        wait_change("chg1_seen");
        chk("chg1_db", 32'(sw_db), 32'h00F);
        flash_run(10'h00F, n);
        chk("flash1_len", 32'(n), 32'(FLASH_TICKS * TICK_DIV - 1));
        chk("flash1_exit", 32'(owner), 32'd1);

        // Two-tick glitch must be rejected.
        sw_raw = 10'h00E;
        pulses = 0;
        off_owner = 0;
        for (int k = 0; k < 48; k++) begin
            if (k == 8) sw_raw = 10'h00F;
            step();
            if (sw_change) pulses++;
            if (owner != 2'd1) off_owner++;
        end
        chk("glitch_pulses", 32'(pulses), 32'd0);
        chk("glitch_owner", 32'(off_owner), 32'd0);
        chk("glitch_db", 32'(sw_db), 32'h00F);

        // Retrigger inside FLASH.
        sw_raw = 10'h0FF;
        wait_change("chg2a_seen");
        chk("chg2a_db", 32'(sw_db), 32'h0FF);
        step();
        sw_raw = 10'h0F3;
        wait_change("chg2b_seen");
        chk("retrig_owner", 32'(owner), 32'd2);
        flash_run(10'h0F3, n);
        chk("retrig_len", 32'(n), 32'(FLASH_TICKS * TICK_DIV - 1));

        // Reset in the middle of FLASH.
        sw_raw = 10'h3FF;
        wait_change("chg3_seen");
        repeat (3) step();
        chk("pre_rst_owner", 32'(owner), 32'd2);
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_led", 32'(led_out), 32'h001);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_sw_db", 32'(sw_db), 32'd0);
        model_reset();
        sw_raw = '0;
        hps_h2f_rst_n = 1'b0;
        repeat (3) step();
        reset_reset_n = 1'b1;
        repeat (8) step();
        chk("restart_led0", 32'(led_out), 32'h001);
        chk("restart_owner", 32'(owner), 32'd0);
        step();
        chk("restart_led1", 32'(led_out), 32'h002);

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            n = $urandom_range(0, 99);
            if (n < 4) begin
                sw_raw = 10'($urandom);
            end else if (n < 9) begin
                idx = $urandom_range(0, 9);
                sw_raw[idx] = ~sw_raw[idx];
            end
            if ($urandom_range(0, 99) < 2) hps_h2f_rst_n = ~hps_h2f_rst_n;
            hps_leds = 10'($urandom);
            step();
        end

        // Settled-state vectors.
        for (int v = 0; v < 6; v++) begin
            sw_raw        = vecs[v].sw;
            hps_h2f_rst_n = vecs[v].hps;
            hps_leds      = vecs[v].leds;
            repeat (vecs[v].hold) step();
            chk("vec_owner", 32'(owner), 32'(vecs[v].exp_owner));
            chk("vec_sw_db", 32'(sw_db), 32'(vecs[v].exp_db));
            if (vecs[v].chk_led) chk("vec_led", 32'(led_out), 32'(vecs[v].exp_led));
            else chk("vec_led_onehot", 32'($onehot(led_out)), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
